// File: rtl/double_dabble_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : double_dabble_seq_if
// Brief    : Start/busy/done handshake and result bundle for double_dabble_seq
// Revision : 1.0
// ============================================================================
interface double_dabble_seq_if #(
    parameter int INPUT_BITS    = 16,
    parameter int OUTPUT_DIGITS = 5,
    parameter int OUTPUT_BITS   = OUTPUT_DIGITS * 4
);
    logic                   start_i;
    logic [INPUT_BITS-1:0]  binary_i;
    logic                   busy_o;
    logic                   done_o;
    logic [OUTPUT_BITS-1:0] bcd_o;
    logic                   sign_o;
    logic                   overflow_o;

    modport master (
        output start_i, binary_i,
        input  busy_o, done_o, bcd_o, sign_o, overflow_o
    );

    modport slave (
        input  start_i, binary_i,
        output busy_o, done_o, bcd_o, sign_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/double_dabble_seq.sv
`default_nettype none
// ============================================================================
// Module   : double_dabble_seq
// Brief    : Sequential binary-to-BCD converter, one shift-and-add-3 step/clock
// Revision : 1.0
// ============================================================================
module double_dabble_seq #(
    parameter int INPUT_BITS    = 16,
    parameter int OUTPUT_DIGITS = 5,
    parameter int OUTPUT_BITS   = OUTPUT_DIGITS * 4,
    parameter int SIGNED        = 0
) (
    input wire               clk,
    input wire               rst,
    double_dabble_seq_if.slave bus
);
    localparam int c_CNT_W = (INPUT_BITS > 2) ? $clog2(INPUT_BITS) : 1;
    localparam logic [c_CNT_W-1:0]    c_CNT_LOAD = c_CNT_W'(INPUT_BITS - 1);
    localparam logic [INPUT_BITS-1:0] c_ONE      = INPUT_BITS'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_next;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [INPUT_BITS-1:0]  r_mag;
    logic [OUTPUT_BITS-1:0] r_work;
    logic                   r_ovf;
    logic                   r_neg;
    logic                   r_done;
    logic [OUTPUT_BITS-1:0] r_bcd;
    logic                   r_sign;
    logic                   r_ovf_out;

    logic                   w_accept;
    logic                   w_step;
    logic                   w_load;
    logic                   w_busy;
    logic                   w_neg;
    logic [INPUT_BITS-1:0]  w_mag;
    logic [OUTPUT_BITS-1:0] w_adj;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.start_i) w_next = c_SHIFT;
            c_SHIFT: if (r_cnt == '0) w_next = c_DONE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_load   = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            c_IDLE:  w_accept = bus.start_i;
            c_SHIFT: begin
                w_step = 1'b1;
                w_busy = 1'b1;
            end
            c_DONE:  begin
                w_load = 1'b1;
                w_busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Negation in INPUT_BITS width makes the most negative value map to 2^(N-1)
    assign w_neg = (SIGNED != 0) && bus.binary_i[INPUT_BITS-1];
    assign w_mag = w_neg ? (~bus.binary_i + c_ONE) : bus.binary_i;

    for (genvar k = 0; k < OUTPUT_DIGITS; k++) begin : g_digit
        assign w_adj[4*k +: 4] = (r_work[4*k +: 4] >= 4'd5) ? (r_work[4*k +: 4] + 4'd3)
                                                             : r_work[4*k +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_mag     <= '0;
            r_work    <= '0;
            r_ovf     <= 1'b0;
            r_neg     <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_sign    <= 1'b0;
            r_ovf_out <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_accept) begin
                r_mag  <= w_mag;
                r_neg  <= w_neg;
                r_work <= '0;
                r_ovf  <= 1'b0;
                r_cnt  <= c_CNT_LOAD;
            end else if (w_step) begin
                // A one leaving the top digit means the value no longer fits
                r_work <= {w_adj[OUTPUT_BITS-2:0], r_mag[INPUT_BITS-1]};
                r_mag  <= {r_mag[INPUT_BITS-2:0], 1'b0};
                r_ovf  <= r_ovf | w_adj[OUTPUT_BITS-1];
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end else if (w_load) begin
                r_bcd     <= r_work;
                r_sign    <= r_neg;
                r_ovf_out <= r_ovf;
            end
        end
    end

    assign bus.busy_o     = w_busy;
    assign bus.done_o     = r_done;
    assign bus.bcd_o      = r_bcd;
    assign bus.sign_o     = r_sign;
    assign bus.overflow_o = r_ovf_out;
endmodule
`default_nettype wire

// File: tb/tb_double_dabble_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_double_dabble_seq
// Brief    : Directed self-checking bench for three double_dabble_seq configs
// Revision : 1.0
// ============================================================================
module tb_double_dabble_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bin;
    int          n_tests = 0;
    int          n_fail  = 0;

    double_dabble_seq_if #(.INPUT_BITS(16), .OUTPUT_DIGITS(5)) dd ();
    double_dabble_seq_if #(.INPUT_BITS(16), .OUTPUT_DIGITS(4)) d4 ();
    double_dabble_seq_if #(.INPUT_BITS(8),  .OUTPUT_DIGITS(3)) ds ();

    assign dd.start_i  = start;
    assign dd.binary_i = bin;
    assign d4.start_i  = start;
    assign d4.binary_i = bin;
    assign ds.start_i  = start;
    assign ds.binary_i = bin[7:0];

    double_dabble_seq #(.INPUT_BITS(16), .OUTPUT_DIGITS(5), .SIGNED(0))
        u_def (.clk(clk), .rst(rst), .bus(dd));
    double_dabble_seq #(.INPUT_BITS(16), .OUTPUT_DIGITS(4), .SIGNED(0))
        u_d4 (.clk(clk), .rst(rst), .bus(d4));
    double_dabble_seq #(.INPUT_BITS(8), .OUTPUT_DIGITS(3), .SIGNED(1))
        u_sg (.clk(clk), .rst(rst), .bus(ds));

    always #5 clk = ~clk;

    // Launch one conversion on all DUTs and wait for the 16-bit default DUT's Done
    task automatic convert(input logic [15:0] v, output int lat, output int busy_n,
                           output bit to);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        lat    = 0;
        busy_n = 0;
        to     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dd.done_o) begin
                to = 1'b0;
                break;
            end
            if (dd.busy_o) busy_n++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({dd.bcd_o, dd.busy_o, dd.done_o, dd.sign_o, dd.overflow_o} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_def: got %h expected 000000",
                     {dd.bcd_o, dd.busy_o, dd.done_o, dd.sign_o, dd.overflow_o});
        end
        n_tests++;
        if ({d4.bcd_o, ds.bcd_o, ds.sign_o, ds.busy_o} !== 30'h0) begin
            n_fail++;
            $display("FAIL reset_other: got %h expected 0",
                     {d4.bcd_o, ds.bcd_o, ds.sign_o, ds.busy_o});
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_timing();
        int lat, busy_n;
        bit to;
        convert(16'd0, lat, busy_n, to);
        n_tests++;
        if (to || lat != 17) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d (timeout=%0d) expected 17", lat, to);
        end
        n_tests++;
        if (busy_n != 17) begin
            n_fail++;
            $display("FAIL zero_busy_cycles: got %0d expected 17", busy_n);
        end
        n_tests++;
        if ({dd.bcd_o, dd.overflow_o, dd.sign_o, dd.busy_o} !== 23'h0) begin
            n_fail++;
            $display("FAIL zero_result: got %h expected 0",
                     {dd.bcd_o, dd.overflow_o, dd.sign_o, dd.busy_o});
        end
        @(negedge clk);
        n_tests++;
        if (dd.done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse_width: got %b expected 0", dd.done_o);
        end
    endtask

    task automatic test_unsigned();
        logic [15:0] vin [13] = '{16'd0, 16'd1, 16'd9, 16'd10, 16'd99, 16'd100, 16'd255,
                                  16'd1000, 16'd9999, 16'd10000, 16'd12345, 16'd32768,
                                  16'd65535};
        logic [19:0] exp [13] = '{20'h00000, 20'h00001, 20'h00009, 20'h00010, 20'h00099,
                                  20'h00100, 20'h00255, 20'h01000, 20'h09999, 20'h10000,
                                  20'h12345, 20'h32768, 20'h65535};
        int lat, busy_n;
        bit to;
        for (int i = 0; i < 13; i++) begin
            convert(vin[i], lat, busy_n, to);
            n_tests++;
            if (to || dd.bcd_o !== exp[i] || dd.overflow_o !== 1'b0 || dd.sign_o !== 1'b0) begin
                n_fail++;
                $display("FAIL unsigned_%0d: got bcd=%h ovf=%b sign=%b to=%0d expected bcd=%h ovf=0 sign=0",
                         vin[i], dd.bcd_o, dd.overflow_o, dd.sign_o, to, exp[i]);
            end
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (dd.bcd_o !== 20'h65535) begin
            n_fail++;
            $display("FAIL result_hold: got %h expected 65535", dd.bcd_o);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] vin [3]  = '{16'd12345, 16'd9999, 16'd10000};
        logic [15:0] exp [3]  = '{16'h2345, 16'h9999, 16'h0000};
        logic        eovf [3] = '{1'b1, 1'b0, 1'b1};
        int lat, busy_n;
        bit to;
        for (int i = 0; i < 3; i++) begin
            convert(vin[i], lat, busy_n, to);
            n_tests++;
            if (to || d4.bcd_o !== exp[i] || d4.overflow_o !== eovf[i]) begin
                n_fail++;
                $display("FAIL overflow_%0d: got bcd=%h ovf=%b expected bcd=%h ovf=%b",
                         vin[i], d4.bcd_o, d4.overflow_o, exp[i], eovf[i]);
            end
        end
    endtask

    task automatic test_signed();
        logic [7:0]  vin [4]  = '{8'h80, 8'hFF, 8'h7F, 8'h00};
        logic [11:0] exp [4]  = '{12'h128, 12'h001, 12'h127, 12'h000};
        logic        esgn [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int lat, busy_n;
        bit to;
        for (int i = 0; i < 4; i++) begin
            convert({8'h00, vin[i]}, lat, busy_n, to);
            n_tests++;
            if (to || ds.bcd_o !== exp[i] || ds.sign_o !== esgn[i] || ds.overflow_o !== 1'b0) begin
                n_fail++;
                $display("FAIL signed_%h: got bcd=%h sign=%b ovf=%b expected bcd=%h sign=%b ovf=0",
                         vin[i], ds.bcd_o, ds.sign_o, ds.overflow_o, exp[i], esgn[i]);
            end
        end
    endtask

    // Leaves the bench at the sample point of the Done cycle
    task automatic test_ignore_start();
        int lat = 0;
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd1234;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b1;
        bin   = 16'd999;
        @(posedge clk);
        lat++;
        @(negedge clk);
        start = 1'b0;
        while (!dd.done_o && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_tests++;
        if (lat != 17 || dd.bcd_o !== 20'h01234) begin
            n_fail++;
            $display("FAIL ignore_start: got lat=%0d bcd=%h expected lat=17 bcd=01234",
                     lat, dd.bcd_o);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        start = 1'b1;
        bin   = 16'd42;
        @(posedge clk);
        n++;
        @(negedge clk);
        start = 1'b0;
        while (!dd.done_o && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        n_tests++;
        if (n != 18 || dd.bcd_o !== 20'h00042) begin
            n_fail++;
            $display("FAIL back_to_back: got gap=%0d bcd=%h expected gap=18 bcd=00042",
                     n, dd.bcd_o);
        end
    endtask

    task automatic test_abort();
        int lat, busy_n;
        bit to;
        bit saw = 1'b0;
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd4321;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({dd.bcd_o, dd.busy_o, dd.done_o, dd.sign_o, dd.overflow_o, d4.bcd_o} !== 40'h0) begin
            n_fail++;
            $display("FAIL abort_clear: got %h expected 0",
                     {dd.bcd_o, dd.busy_o, dd.done_o, dd.sign_o, dd.overflow_o, d4.bcd_o});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (dd.done_o) saw = 1'b1;
        end
        n_tests++;
        if (saw) begin
            n_fail++;
            $display("FAIL abort_no_done: got done=1 expected none");
        end
        convert(16'd777, lat, busy_n, to);
        n_tests++;
        if (to || lat != 17 || dd.bcd_o !== 20'h00777) begin
            n_fail++;
            $display("FAIL after_abort: got lat=%0d bcd=%h expected lat=17 bcd=00777",
                     lat, dd.bcd_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bin   = 16'd0;
        test_reset();
        test_zero_timing();
        test_unsigned();
        test_overflow();
        test_signed();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/double_dabble_seq.md
# double_dabble_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm. It performs one bit-step per clock, so logic is a single add-3 stage per digit instead of an unrolled combinational network. It adds a start/busy/done handshake, a registered result, overflow detection and an optional two's-complement signed mode. It sits between arithmetic datapaths and display drivers (7-segment, LCD, UART text).

## Interface
- INPUT_BITS, 16, width of Binary_i (≥2)
- OUTPUT_DIGITS, 5, number of BCD digits produced (≥1)
- OUTPUT_BITS, OUTPUT_DIGITS*4, derived, not to be overridden
- SIGNED, 0, 0: Binary_i is unsigned; 1: Binary_i is two's complement
- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high
- Start_i  input  1  request conversion of Binary_i
- Binary_i  input  INPUT_BITS  value to convert, sampled only on an accepted Start_i
- Busy_o  output  1  conversion in progress
- Done_o  output  1  one-cycle pulse, result valid
- BCD_o  output  OUTPUT_BITS  result; digit k at [4k+3:4k], digit 0 least significant
- Sign_o  output  1  result is negative (always 0 when SIGNED=0)
- Overflow_o  output  1  magnitude exceeded 10^OUTPUT_DIGITS−1

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Start_i=1 at an edge is accepted.
  - The magnitude is latched into an INPUT_BITS shift register. For SIGNED=1 with MSB=1 the magnitude is the negation, computed in INPUT_BITS width unsigned, so −2^(INPUT_BITS−1) yields 2^(INPUT_BITS−1).
  - The sign flag is latched, the working BCD register is cleared, the overflow flag is cleared, the bit counter is loaded with INPUT_BITS−1, and the state goes to SHIFT.
- SHIFT, one step per edge:
  - Every working digit ≥5 gets +3, mod 16.
  - The working register then shifts left one bit, taking the MSB of the magnitude register. The magnitude register also shifts left.
  - If the bit shifted out of working[OUTPUT_BITS−1] is 1, the overflow flag is set (sticky).
  - When the counter is 0, go to DONE. Otherwise decrement.
- DONE, one cycle: BCD_o, Sign_o and Overflow_o are loaded from the working state, Done_o=1 and the state returns to IDLE.
- Overflow: BCD_o holds the value mod 10^OUTPUT_DIGITS, with the lower digits correct.
- Sign_o=0 whenever the magnitude is 0.
- Start_i while Busy_o=1 is ignored; the in-flight conversion is unaffected. There is no queueing.
- BCD_o, Sign_o and Overflow_o change only in the DONE transition and hold between conversions.

## Timing
- Reset asserted:
  - Outputs go immediately to BCD_o=0, Sign_o=0, Overflow_o=0, Busy_o=0, Done_o=0.
  - State goes to IDLE and internal registers clear.
- Reset mid-conversion aborts the conversion, and no Done_o is produced.
- The first edge after Reset deassertion may accept Start_i.
- Start accepted at edge E0:
  - Busy_o=1 from E0 through E(INPUT_BITS+1).
  - Iteration steps occur at edges E1..E(INPUT_BITS).
  - At E(INPUT_BITS+1) the outputs are loaded, Done_o goes to 1 and Busy_o goes to 0.
  - Done_o falls at E(INPUT_BITS+2).
- Latency is INPUT_BITS+1 clocks from the accepting edge to the Done_o rising edge. Throughput is one conversion per INPUT_BITS+2 clocks.
- Busy_o is a registered state decode, not combinational from Start_i.
- Start_i high during the Done_o cycle is accepted at E(INPUT_BITS+2), so back-to-back operation has no idle gap.
- Start_i held high continuously triggers a new conversion every INPUT_BITS+2 clocks.

## Test plan
- Defaults, Binary_i=0, single Start_i → Done_o exactly 17 clocks after the accepting edge, BCD_o=20'h00000, Overflow_o=0, Sign_o=0, Busy_o high for 17 cycles.
- Defaults, sweep 0..65535 including 65535 → BCD_o=20'h65535 for 65535. Every value is checked against a reference decimal conversion, with Overflow_o=0 throughout.
- INPUT_BITS=16, OUTPUT_DIGITS=4, Binary_i=12345 → BCD_o=16'h2345, Overflow_o=1. Then 9999 → 16'h9999, Overflow_o=0 (flag cleared per conversion).
- SIGNED=1, INPUT_BITS=8, OUTPUT_DIGITS=3:
  - 8'h80 → 12'h128, Sign_o=1
  - 8'hFF → 12'h001, Sign_o=1
  - 8'h7F → 12'h127, Sign_o=0
  - 8'h00 → 12'h000, Sign_o=0
- Start_i pulsed mid-conversion with a different Binary_i → ignored, and the first result is unchanged. Start_i during the Done_o cycle → second Done_o exactly 18 clocks after the first.
- Reset asserted asynchronously (between edges) 5 clocks into a conversion → all outputs 0 immediately, no Done_o. A new Start_i after release converts correctly.
